mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_wb_reg.sv | 45 ++++
 rtl/mem_stage_ctrl.sv | 110 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage controller.
package mem_stage_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEST_W = 5;
  localparam int CNT_W  = 8;
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: bubble clears the control bits, load captures a new instruction.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              load_data,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_data,
  output logic [DEST_W-1:0] dest
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      pc         <= '0;
      alu_result <= '0;
      mem_data   <= '0;
      dest       <= '0;
    end else if (bubble) begin
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
    end else if (load) begin
      wb_en      <= wb_en_in;
      mem_r_en   <= mem_r_en_in;
      pc         <= pc_in;
      alu_result <= alu_result_in;
      dest       <= dest_in;
      if (load_data) mem_data <= data_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues one memory access at a time and stalls the pipe until it completes.
// state  | meaning
// IDLE   | no access outstanding; a pending load/store is launched this cycle
// ACCESS | mem_req held high, waiting for mem_ready or the wait timeout
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_data,
  output logic [DEST_W-1:0] dest,
  output logic              mem_err
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               pending, timeout, done, launch;
  logic [DATA_W-1:0]  rd_data;

  always_comb begin
    pending   = mem_r_en_in | mem_w_en_in;
    // A real ready always beats a coincident timeout.
    timeout   = (state == S_ACCESS) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT));
    done      = (state == S_ACCESS) && (mem_ready || timeout);
    launch    = (state == S_IDLE) && pending;
    rd_data   = mem_ready ? mem_rdata : ERR_DATA;
    freeze    = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        freeze = pending;
        if (pending) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        freeze = !done;
        if (done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
    end else if (launch) begin
      wait_cnt  <= '0;
      mem_req   <= 1'b1;
      mem_we    <= mem_w_en_in & ~mem_r_en_in;
      mem_addr  <= alu_result_in;
      mem_wdata <= st_val_in;
    end else if (done) begin
      mem_req <= 1'b0;
      if (timeout) mem_err <= 1'b1;
    end else if (state == S_ACCESS) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (!freeze),
    .bubble       (freeze),
    .load_data    (done && !mem_we),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .pc_in        (pc_in),
    .alu_result_in(alu_result_in),
    .data_in      (rd_data),
    .dest_in      (dest_in),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .pc           (pc),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .dest         (dest)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed table, reset-abort sequence, random instruction stream.
module tb_mem_stage_ctrl;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, mem_ready = 0;
  logic [31:0] pc_in = 0, alu_result_in = 0, st_val_in = 0, mem_rdata = 0;
  logic [4:0] dest_in = 0;
  logic freeze, mem_req, mem_we, wb_en, mem_r_en, mem_err;
  logic [31:0] mem_addr, mem_wdata, pc, alu_result, mem_data;
  logic [4:0] dest;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .pc_in(pc_in), .alu_result_in(alu_result_in),
    .st_val_in(st_val_in), .dest_in(dest_in), .freeze(freeze), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .mem_r_en(mem_r_en), .pc(pc),
    .alu_result(alu_result), .mem_data(mem_data), .dest(dest), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, wb;
    logic [31:0] pc, alu, st, rdata;
    logic [4:0] dest;
    int delay;        // ACCESS cycles before mem_ready; beyond TO means never
    int exp_freeze;
    logic exp_we;
    logic [31:0] exp_data;
    logic exp_err;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] m_data;
  logic m_err;

  function automatic vec_t mkv(logic rd, logic wr, logic wb, logic [31:0] p, logic [31:0] a,
                               logic [31:0] s, logic [31:0] rdat, logic [4:0] d, int dl,
                               int ef, logic ewe, logic [31:0] ed, logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.wb = wb; v.pc = p; v.alu = a; v.st = s; v.rdata = rdat;
    v.dest = d; v.delay = dl; v.exp_freeze = ef; v.exp_we = ewe; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; mem_ready = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int nfrz;
    logic stable_ok, bubble_ok, we_seen;
    @(negedge clk);
    wb_en_in = v.wb; mem_r_en_in = v.rd; mem_w_en_in = v.wr;
    pc_in = v.pc; alu_result_in = v.alu; st_val_in = v.st; dest_in = v.dest;
    mem_ready = 1'($urandom_range(0, 1));  // must be ignored while mem_req=0
    mem_rdata = $urandom;
    nfrz = 0; stable_ok = 1; bubble_ok = 1; we_seen = 0;
    if (v.rd || v.wr) begin
      for (int c = 0; c < 20; c++) begin
        if (c > 0) begin
          mem_ready = ((c - 1) == v.delay);
          mem_rdata = ((c - 1) == v.delay) ? v.rdata : $urandom;
        end
        #1;
        if (c == 1) we_seen = mem_we;
        if (c > 0) begin
          if (!(mem_req && mem_we == v.exp_we && mem_addr == v.alu && mem_wdata == v.st))
            stable_ok = 0;
          if (wb_en || mem_r_en) bubble_ok = 0;
        end
        if (!freeze) break;
        nfrz++;
        @(negedge clk);
      end
      chk("access_stable", 32'(stable_ok), 32'd1);
      chk("stall_bubble", 32'(bubble_ok), 32'd1);
      chk("mem_we", 32'(we_seen), 32'(v.exp_we));
    end else begin
      #1;
      nfrz = freeze ? 1 : 0;
    end
    chk("freeze_cycles", nfrz, v.exp_freeze);
    @(negedge clk);
    chk("mem_req_done", 32'(mem_req), 32'd0);
    chk("wb_en", 32'(wb_en), 32'(v.wb));
    chk("mem_r_en", 32'(mem_r_en), 32'(v.rd));
    chk("pc", pc, v.pc);
    chk("alu_result", alu_result, v.alu);
    chk("dest", 32'(dest), 32'(v.dest));
    chk("mem_data", mem_data, v.exp_data);
    chk("mem_err", 32'(mem_err), 32'(v.exp_err));
    clear_inputs();
    m_data = v.exp_data;
    m_err  = v.exp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int t, waited;
    logic to_hit;

    vecs[0] = mkv(0, 0, 1, 32'h100, 32'h10, 32'h0, 32'h0, 5'd3, 0, 0, 0, 32'h0, 0);
    vecs[1] = mkv(1, 0, 1, 32'h104, 32'h40, 32'h0, 32'hCAFE0001, 5'd5, 0, 1, 0, 32'hCAFE0001, 0);
    vecs[2] = mkv(0, 1, 0, 32'h108, 32'h80, 32'h55, 32'h0, 5'd0, 3, 4, 1, 32'hCAFE0001, 0);
    vecs[3] = mkv(1, 1, 1, 32'h10C, 32'h84, 32'h77, 32'h12345678, 5'd7, 1, 2, 0, 32'h12345678, 0);
    vecs[4] = mkv(1, 0, 1, 32'h110, 32'h44, 32'h0, 32'h0, 5'd9, 99, 5, 0, ERRD, 1);
    vecs[5] = mkv(0, 0, 1, 32'h114, 32'h20, 32'h0, 32'h0, 5'd4, 0, 0, 0, ERRD, 1);
    vecs[6] = mkv(1, 0, 1, 32'h118, 32'h48, 32'h0, 32'hA5A5A5A5, 5'd11, TO, 5, 0, 32'hA5A5A5A5, 1);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {mem_req, mem_we, wb_en, mem_r_en, mem_err} | mem_addr | mem_wdata
        | pc | alu_result | mem_data | 32'(dest), 32'd0);
    chk("reset_freeze", 32'(freeze), 32'd0);
    rst = 1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset in the middle of an access abandons it
    @(negedge clk);
    mem_r_en_in = 1; wb_en_in = 1; pc_in = 32'h200; alu_result_in = 32'h60; dest_in = 5'd2;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_access_req", 32'(mem_req), 32'd1);
    #1 rst = 0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_all_zero", {mem_req, mem_we, wb_en, mem_r_en, mem_err} | mem_addr | mem_wdata
        | pc | alu_result | mem_data | 32'(dest), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1;
    #1 chk("post_reset_freeze", 32'(freeze), 32'd0);
    chk("post_reset_err", 32'(mem_err), 32'd0);
    // with a request pending and ready high, only IDLE can still be freezing
    mem_r_en_in = 1; mem_ready = 1;
    #1 chk("post_reset_idle", 32'(freeze), 32'd1);
    clear_inputs();
    m_data = 32'h0;
    m_err  = 1'b0;

    // random instruction stream against the transaction-level model
    for (int n = 0; n < 60; n++) begin
      t = $urandom_range(0, 3);
      v.rd = (t == 1 || t == 3);
      v.wr = (t == 2 || t == 3);
      v.wb = 1'($urandom_range(0, 1));
      v.pc = $urandom; v.alu = $urandom; v.st = $urandom; v.rdata = $urandom;
      v.dest = 5'($urandom_range(0, 31));
      v.delay = $urandom_range(0, TO + 2);
      waited = (v.delay <= TO) ? v.delay : TO;
      to_hit = (v.rd || v.wr) && (v.delay > TO);
      v.exp_freeze = (v.rd || v.wr) ? 1 + waited : 0;
      v.exp_we = v.wr && !v.rd;
      v.exp_data = v.rd ? (to_hit ? ERRD : v.rdata) : m_data;
      v.exp_err = m_err | to_hit;
      run_vec(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
